video_format_detector: RTL and testbench

VIDEO_FORMAT_DETECTOR -- requirements
Module: video_format_detector

---
 rtl/video_format_detector_if.sv | 30 +++
 rtl/video_format_detector.sv | 114 +++++++++++
 tb/tb_video_format_detector.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_format_detector_if.sv
// Video timing bundle: raw de/hs/vs from the source and the measured format back to the sink.
interface video_format_detector_if #(
  parameter int MAX_WIDTH  = 1920,
  parameter int MAX_HEIGHT = 1080
);
  localparam int WO = $clog2(MAX_WIDTH);
  localparam int HO = $clog2(MAX_HEIGHT);

  logic          I_rgb_de;
  logic          I_rgb_hs;
  logic          I_rgb_vs;
  logic [WO-1:0] O_image_width;
  logic [HO-1:0] O_image_height;
  logic          O_image_valid;
  logic          O_frame_start;
  logic          O_line_start;
  logic          O_format_changed;

  modport master (
    output I_rgb_de, I_rgb_hs, I_rgb_vs,
    input  O_image_width, O_image_height, O_image_valid,
           O_frame_start, O_line_start, O_format_changed
  );

  modport slave (
    input  I_rgb_de, I_rgb_hs, I_rgb_vs,
    output O_image_width, O_image_height, O_image_valid,
           O_frame_start, O_line_start, O_format_changed
  );
endinterface

// File: rtl/video_format_detector.sv
// Measures active width/height from de/vs and declares the format valid once
// STABLE_FRAMES consecutive good frames of identical size have been seen.
module video_format_detector #(
  parameter int MAX_WIDTH     = 1920,
  parameter int MAX_HEIGHT    = 1080,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                   I_rgb_clk,
  input  logic                   I_rst_n,
  video_format_detector_if.slave vid
);
  localparam int WO = $clog2(MAX_WIDTH);
  localparam int HO = $clog2(MAX_HEIGHT);
  localparam int CW = $clog2(MAX_WIDTH + 2);
  localparam int LW = $clog2(MAX_HEIGHT + 2);
  localparam int SW = 4;
  localparam logic [CW-1:0] PIX_SAT  = CW'(MAX_WIDTH + 1);
  localparam logic [LW-1:0] LINE_SAT = LW'(MAX_HEIGHT + 1);
  localparam logic [SW-1:0] STABLE_N = SW'(STABLE_FRAMES);

  logic          de_p0, vs_p0;
  logic [CW-1:0] pix_cnt, frame_w, prev_w, img_w;
  logic [LW-1:0] line_cnt, prev_h, img_h;
  logic          line_act, err;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic          valid, frame_start, line_start, changed;
  logic          de_rise, de_fall, vs_rise;
  logic          good, same, valid_nxt;

  // Edges are seen at the clock edge that loads the new registered value.
  assign de_rise = vid.I_rgb_de & ~de_p0;
  assign de_fall = ~vid.I_rgb_de & de_p0;
  assign vs_rise = vid.I_rgb_vs & ~vs_p0;

  always_comb begin
    good = ~err && (frame_w != '0) && (frame_w <= CW'(MAX_WIDTH))
           && (line_cnt != '0) && (line_cnt <= LW'(MAX_HEIGHT));
    same = (frame_w == prev_w) && (line_cnt == prev_h);
    stable_nxt = '0;
    if (good && same)
      stable_nxt = (stable_cnt >= STABLE_N) ? STABLE_N : stable_cnt + 1'b1;
    else if (good)
      stable_nxt = SW'(1);
    valid_nxt = (stable_nxt == STABLE_N);
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_p0       <= 1'b0;
      vs_p0       <= 1'b0;
      pix_cnt     <= '0;
      frame_w     <= '0;
      prev_w      <= '0;
      img_w       <= '0;
      line_cnt    <= '0;
      prev_h      <= '0;
      img_h       <= '0;
      line_act    <= 1'b0;
      err         <= 1'b0;
      stable_cnt  <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      changed     <= 1'b0;
    end else begin
      de_p0       <= vid.I_rgb_de;
      vs_p0       <= vid.I_rgb_vs;
      frame_start <= vs_rise;
      line_start  <= de_rise & ~vid.I_rgb_hs;
      changed     <= 1'b0;
      if (vs_rise) begin
        // Close the frame; any line still in progress is dropped.
        prev_w     <= frame_w;
        prev_h     <= line_cnt;
        stable_cnt <= stable_nxt;
        valid      <= valid_nxt;
        if (valid_nxt) begin
          img_w <= frame_w;
          img_h <= line_cnt;
        end
        changed  <= (valid & ~valid_nxt) |
                    (valid_nxt & ((frame_w != img_w) || (line_cnt != img_h)));
        pix_cnt  <= '0;
        frame_w  <= '0;
        line_cnt <= '0;
        err      <= 1'b0;
        line_act <= 1'b0;
      end else begin
        if (de_rise) begin
          pix_cnt  <= CW'(1);
          line_act <= 1'b1;
        end else if (vid.I_rgb_de && pix_cnt != PIX_SAT) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
        if (de_fall && line_act) begin
          line_act <= 1'b0;
          if (line_cnt == '0)
            frame_w <= pix_cnt;
          else if (pix_cnt != frame_w)
            err <= 1'b1;
          if (line_cnt != LINE_SAT)
            line_cnt <= line_cnt + 1'b1;
        end
      end
    end
  end

  assign vid.O_image_width    = img_w[WO-1:0];
  assign vid.O_image_height   = img_h[HO-1:0];
  assign vid.O_image_valid    = valid;
  assign vid.O_frame_start    = frame_start;
  assign vid.O_line_start     = line_start;
  assign vid.O_format_changed = changed;
endmodule

// File: tb/tb_video_format_detector.sv
// Bench for video_format_detector: drives de/hs/vs frames and compares against a
// frame-level model built from the list of line lengths of each frame.
module tb_video_format_detector;
  localparam int MAXW = 1920;
  localparam int MAXH = 1080;
  localparam int SF   = 2;
  localparam int WO   = $clog2(MAXW);
  localparam int HO   = $clog2(MAXH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  video_format_detector_if #(.MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH)) vif ();

  video_format_detector #(.MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH), .STABLE_FRAMES(SF)) dut (
    .I_rgb_clk (clk),
    .I_rst_n   (rst_n),
    .vid       (vif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Pulse monitors
  int   fs_cnt = 0, ls_cnt = 0, chg_cnt = 0, vrise_cnt = 0, wide_cnt = 0;
  logic prev_fs = 1'b0, prev_ls = 1'b0, prev_chg = 1'b0, prev_valid = 1'b0;
  always @(negedge clk) begin
    if (vif.O_frame_start === 1'b1) fs_cnt++;
    if (vif.O_line_start === 1'b1) ls_cnt++;
    if (vif.O_format_changed === 1'b1) chg_cnt++;
    if (vif.O_image_valid === 1'b1 && prev_valid !== 1'b1) vrise_cnt++;
    if ((vif.O_frame_start === 1'b1 && prev_fs === 1'b1) ||
        (vif.O_line_start === 1'b1 && prev_ls === 1'b1) ||
        (vif.O_format_changed === 1'b1 && prev_chg === 1'b1)) wide_cnt++;
    prev_fs    = vif.O_frame_start;
    prev_ls    = vif.O_line_start;
    prev_chg   = vif.O_format_changed;
    prev_valid = vif.O_image_valid;
  end

  // Frame-level reference model
  int m_lens[$];
  int m_prev_w = 0, m_prev_h = 0, m_stable = 0, m_w = 0, m_h = 0;
  bit m_valid = 1'b0, m_chg = 1'b0;

  function automatic int satw(input int x);
    return (x > MAXW + 1) ? MAXW + 1 : x;
  endfunction

  task automatic model_close();
    int fw, fh;
    bit good, nv;
    fh = m_lens.size();
    fw = (fh > 0) ? satw(m_lens[0]) : 0;
    good = (fh >= 1) && (fh <= MAXH) && (fw >= 1) && (fw <= MAXW);
    foreach (m_lens[i]) if (satw(m_lens[i]) != fw) good = 1'b0;
    if (!good) m_stable = 0;
    else if (fw == m_prev_w && fh == m_prev_h) m_stable = (m_stable + 1 > SF) ? SF : m_stable + 1;
    else m_stable = 1;
    nv = (m_stable == SF);
    m_chg = (m_valid && !nv) || (nv && (fw != m_w || fh != m_h));
    if (nv) begin
      m_w = fw;
      m_h = fh;
    end
    m_valid  = nv;
    m_prev_w = fw;
    m_prev_h = fh;
    m_lens.delete();
  endtask

  task automatic model_reset();
    m_lens.delete();
    m_prev_w = 0; m_prev_h = 0; m_stable = 0; m_w = 0; m_h = 0;
    m_valid = 1'b0; m_chg = 1'b0;
  endtask

  // Stimulus drivers; observations are left in obs_* for the calling test.
  logic          obs_fs, obs_fs_next, obs_valid, obs_chg, obs_chg_next;
  logic [WO-1:0] obs_w;
  logic [HO-1:0] obs_h;
  logic          obs_rst_any, obs_rel_any;

  task automatic vs_edge();
    @(negedge clk);
    vif.I_rgb_vs = 1'b1;
    vif.I_rgb_de = 1'b0;
    vif.I_rgb_hs = 1'b0;
    model_close();
    @(negedge clk);
    obs_fs    = vif.O_frame_start;
    obs_valid = vif.O_image_valid;
    obs_w     = vif.O_image_width;
    obs_h     = vif.O_image_height;
    obs_chg   = vif.O_format_changed;
    @(negedge clk);
    obs_fs_next  = vif.O_frame_start;
    obs_chg_next = vif.O_format_changed;
    @(negedge clk);
    vif.I_rgb_vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_body(input int nl, input int w, input int bad_line, input int bad_len,
                            input int blank, input int hs_line, input int rst_line);
    int len;
    for (int i = 0; i < nl; i++) begin
      len = (i == bad_line) ? bad_len : w;
      if (i == hs_line) begin
        @(negedge clk);
        vif.I_rgb_hs = 1'b1;
      end
      for (int p = 0; p < len; p++) begin
        @(negedge clk);
        vif.I_rgb_de = 1'b1;
        if (i == hs_line && p == 2) vif.I_rgb_hs = 1'b0;
        if (i == rst_line && p == len / 2) begin
          rst_n = 1'b0;
          #1;
          obs_rst_any = |{vif.O_image_valid, vif.O_image_width, vif.O_image_height,
                          vif.O_frame_start, vif.O_line_start, vif.O_format_changed};
        end
      end
      for (int b = 0; b < blank; b++) begin
        @(negedge clk);
        vif.I_rgb_de = 1'b0;
        vif.I_rgb_hs = (b >= 4 && b < 8);
        if (b == 0) m_lens.push_back(len);
        if (i == rst_line && b == 0) begin
          rst_n = 1'b1;
          model_reset();
        end
        if (i == rst_line && b == 1)
          obs_rel_any = vif.O_frame_start | vif.O_line_start | vif.O_format_changed;
      end
    end
    @(negedge clk);
    vif.I_rgb_hs = 1'b0;
    repeat (160) @(negedge clk);
  endtask

  task automatic test_reset();
    vif.I_rgb_de = 1'b0;
    vif.I_rgb_hs = 1'b0;
    vif.I_rgb_vs = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({vif.O_image_valid, vif.O_frame_start, vif.O_line_start, vif.O_format_changed} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got valid/fs/ls/chg=%b, want 0000",
               {vif.O_image_valid, vif.O_frame_start, vif.O_line_start, vif.O_format_changed});
    end
    n_checks++;
    if (vif.O_image_width !== '0 || vif.O_image_height !== '0) begin
      n_err++;
      $display("FAIL reset_size: got %0dx%0d, want 0x0", vif.O_image_width, vif.O_image_height);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (fs_cnt != 0 || ls_cnt != 0 || chg_cnt != 0) begin
      n_err++;
      $display("FAIL reset_release_pulses: got fs=%0d ls=%0d chg=%0d, want 0 0 0", fs_cnt, ls_cnt, chg_cnt);
    end
  endtask

  task automatic test_stable_32x8();
    int c0;
    c0 = chg_cnt;
    for (int f = 0; f < 5; f++) begin
      vs_edge();
      n_checks++;
      if (obs_valid !== m_valid || obs_w !== WO'(m_w) || obs_h !== HO'(m_h) || obs_chg !== m_chg ||
          obs_fs !== 1'b1 || obs_fs_next !== 1'b0 || obs_chg_next !== 1'b0) begin
        n_err++;
        $display("FAIL stable edge%0d: got v=%0b %0dx%0d chg=%0b fs=%0b%0b, want v=%0b %0dx%0d chg=%0b fs=10",
                 f, obs_valid, obs_w, obs_h, obs_chg, obs_fs, obs_fs_next, m_valid, m_w, m_h, m_chg);
      end
      n_checks++;
      if (obs_valid !== (f >= 2)) begin
        n_err++;
        $display("FAIL stable_valid_timing edge%0d: got %0b, want %0b", f, obs_valid, f >= 2);
      end
      if (f < 4) frame_body(8, 32, -1, 0, 16, -1, -1);
    end
    n_checks++;
    if (obs_w !== WO'(32) || obs_h !== HO'(8) || chg_cnt - c0 != 1) begin
      n_err++;
      $display("FAIL stable_final: got %0dx%0d chg_pulses=%0d, want 32x8 1", obs_w, obs_h, chg_cnt - c0);
    end
  endtask

  task automatic test_pulses();
    int l0, f0;
    for (int f = 0; f < 2; f++) begin
      l0 = ls_cnt;
      f0 = fs_cnt;
      frame_body(8, 32, -1, 0, $urandom_range(12, 20), -1, -1);
      vs_edge();
      n_checks++;
      if (ls_cnt - l0 != 8 || fs_cnt - f0 != 1) begin
        n_err++;
        $display("FAIL pulse_counts frame%0d: got ls=%0d fs=%0d, want 8 1", f, ls_cnt - l0, fs_cnt - f0);
      end
      n_checks++;
      if (obs_valid !== m_valid || obs_chg !== m_chg) begin
        n_err++;
        $display("FAIL pulses edge%0d: got v=%0b chg=%0b, want v=%0b chg=%0b", f, obs_valid, obs_chg, m_valid, m_chg);
      end
    end
  endtask

  task automatic test_bad_line();
    int c0;
    c0 = chg_cnt;
    for (int f = 0; f < 4; f++) begin
      frame_body(8, 32, (f == 0) ? 5 : -1, 31, 16, -1, -1);
      vs_edge();
      n_checks++;
      if (obs_valid !== m_valid || obs_w !== WO'(m_w) || obs_h !== HO'(m_h) || obs_chg !== m_chg) begin
        n_err++;
        $display("FAIL bad_line edge%0d: got v=%0b %0dx%0d chg=%0b, want v=%0b %0dx%0d chg=%0b",
                 f, obs_valid, obs_w, obs_h, obs_chg, m_valid, m_w, m_h, m_chg);
      end
      n_checks++;
      if (obs_valid !== (f >= 2) || obs_w !== WO'(32) || obs_h !== HO'(8)) begin
        n_err++;
        $display("FAIL bad_line_fixed edge%0d: got v=%0b %0dx%0d, want v=%0b 32x8", f, obs_valid, obs_w, obs_h, f >= 2);
      end
    end
    n_checks++;
    if (chg_cnt - c0 != 1) begin
      n_err++;
      $display("FAIL bad_line_chg_pulses: got %0d, want 1", chg_cnt - c0);
    end
  endtask

  task automatic test_switch();
    int c0;
    c0 = chg_cnt;
    for (int f = 0; f < 3; f++) begin
      frame_body(4, 16, -1, 0, 16, -1, -1);
      vs_edge();
      n_checks++;
      if (obs_valid !== m_valid || obs_w !== WO'(m_w) || obs_h !== HO'(m_h) || obs_chg !== m_chg) begin
        n_err++;
        $display("FAIL switch edge%0d: got v=%0b %0dx%0d chg=%0b, want v=%0b %0dx%0d chg=%0b",
                 f, obs_valid, obs_w, obs_h, obs_chg, m_valid, m_w, m_h, m_chg);
      end
    end
    n_checks++;
    if (obs_valid !== 1'b1 || obs_w !== WO'(16) || obs_h !== HO'(4) || chg_cnt - c0 != 2) begin
      n_err++;
      $display("FAIL switch_final: got v=%0b %0dx%0d chg_pulses=%0d, want 1 16x4 2",
               obs_valid, obs_w, obs_h, chg_cnt - c0);
    end
  endtask

  task automatic test_overwidth();
    int v0;
    v0 = vrise_cnt;
    for (int f = 0; f < 4; f++) begin
      frame_body(2, 2000, -1, 0, 16, -1, -1);
      vs_edge();
      n_checks++;
      if (obs_valid !== 1'b0 || obs_valid !== m_valid || obs_chg !== m_chg) begin
        n_err++;
        $display("FAIL overwidth edge%0d: got v=%0b chg=%0b, want v=0 chg=%0b", f, obs_valid, obs_chg, m_chg);
      end
    end
    n_checks++;
    if (vrise_cnt != v0) begin
      n_err++;
      $display("FAIL overwidth_valid_rises: got %0d, want 0", vrise_cnt - v0);
    end
  endtask

  task automatic test_hs_gate();
    int l0;
    l0 = ls_cnt;
    frame_body(8, 32, -1, 0, 16, 0, -1);
    n_checks++;
    if (ls_cnt - l0 != 7) begin
      n_err++;
      $display("FAIL hs_gate_line_starts: got %0d, want 7", ls_cnt - l0);
    end
    vs_edge();
    n_checks++;
    if (obs_valid !== m_valid || obs_chg !== m_chg) begin
      n_err++;
      $display("FAIL hs_gate edge: got v=%0b chg=%0b, want v=%0b chg=%0b", obs_valid, obs_chg, m_valid, m_chg);
    end
  endtask

  task automatic test_mid_reset();
    for (int f = 0; f < 2; f++) begin
      frame_body(8, 32, -1, 0, 16, -1, -1);
      vs_edge();
    end
    n_checks++;
    if (obs_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_precondition: got valid=%0b, want 1", obs_valid);
    end
    obs_rst_any = 1'b1;
    obs_rel_any = 1'b1;
    frame_body(8, 32, -1, 0, 16, -1, 3);
    n_checks++;
    if (obs_rst_any !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got nonzero=%0b, want 0", obs_rst_any);
    end
    n_checks++;
    if (obs_rel_any !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_release_pulse: got %0b, want 0", obs_rel_any);
    end
    for (int e = 1; e <= 3; e++) begin
      vs_edge();
      n_checks++;
      if (obs_valid !== (e == 3) || obs_valid !== m_valid || obs_w !== WO'(m_w) || obs_h !== HO'(m_h)) begin
        n_err++;
        $display("FAIL mid_reset edge%0d: got v=%0b %0dx%0d, want v=%0b %0dx%0d",
                 e, obs_valid, obs_w, obs_h, e == 3, m_w, m_h);
      end
      if (e < 3) frame_body(8, 32, -1, 0, 16, -1, -1);
    end
  endtask

  task automatic test_random();
    int d, w, h, bl, blen;
    for (int f = 0; f < 10; f++) begin
      d = $urandom_range(0, 2);
      w = (d == 0) ? 32 : (d == 1) ? 16 : 24;
      h = (d == 0) ? 8 : (d == 1) ? 4 : 6;
      bl = -1;
      blen = 0;
      if ($urandom_range(0, 3) == 0) begin
        bl = $urandom_range(0, h - 1);
        blen = ($urandom_range(0, 1) == 1) ? w + 1 : w - 1;
      end
      repeat ($urandom_range(0, 2)) begin
        frame_body(h, w, bl, blen, $urandom_range(12, 20), -1, -1);
        vs_edge();
        n_checks++;
        if (obs_valid !== m_valid || obs_w !== WO'(m_w) || obs_h !== HO'(m_h) || obs_chg !== m_chg) begin
          n_err++;
          $display("FAIL random frame%0d: got v=%0b %0dx%0d chg=%0b, want v=%0b %0dx%0d chg=%0b",
                   f, obs_valid, obs_w, obs_h, obs_chg, m_valid, m_w, m_h, m_chg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stable_32x8();
    test_pulses();
    test_bad_line();
    test_switch();
    test_overwidth();
    test_hs_gate();
    test_mid_reset();
    test_random();
    n_checks++;
    if (wide_cnt != 0) begin
      n_err++;
      $display("FAIL pulse_width: got %0d multi-cycle pulses, want 0", wide_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
